// File: rtl/controlador_brinquedo.sv
// Toy robot controller: synchronizes the slow step clock, run switch and obstacle
// sensor, then walks a forward / turn / reverse pattern and counts obstacle hits.

module sincronizador (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sinc_r;

  // Two-flop synchronizer for a single asynchronous level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sinc_r <= 1'b0;
    end else begin
      meta_r <= d;
      sinc_r <= meta_r;
    end
  end

  assign q = sinc_r;

endmodule

module controlador_brinquedo #(
  parameter int PASSOS_FRENTE = 4,
  parameter int PASSOS_GIRO   = 2,
  parameter int PASSOS_RE     = 2
) (
  input  logic       clock_entrada,
  input  logic       botao,
  input  logic       passo,
  input  logic       liga,
  input  logic       obstaculo,
  output logic [1:0] motor_esq,
  output logic [1:0] motor_dir,
  output logic [2:0] estado,
  output logic [3:0] contador_obstaculos
);

  typedef enum logic [2:0] {
    PARADO   = 3'd0,
    FRENTE   = 3'd1,
    GIRA_ESQ = 3'd2,
    GIRA_DIR = 3'd3,
    RE       = 3'd4
  } estado_t;

  localparam logic [3:0] LIM_FRENTE = 4'(PASSOS_FRENTE - 1);
  localparam logic [3:0] LIM_GIRO   = 4'(PASSOS_GIRO - 1);
  localparam logic [3:0] LIM_RE     = 4'(PASSOS_RE - 1);

  logic passo_s;
  logic liga_s;
  logic obst_s;
  logic passo_ant_r;
  logic tick_s;

  estado_t    estado_r;
  estado_t    estado_nxt_s;
  logic [3:0] cont_r;
  logic [3:0] cont_nxt_s;
  logic       lado_r;
  logic       lado_nxt_s;
  logic [3:0] obst_cnt_r;
  logic [3:0] obst_cnt_nxt_s;
  logic [3:0] motores_nxt_s;
  logic [1:0] motor_esq_r;
  logic [1:0] motor_dir_r;

  sincronizador u_sinc_passo (
    .clk   (clock_entrada),
    .rst_n (botao),
    .d     (passo),
    .q     (passo_s)
  );

  sincronizador u_sinc_liga (
    .clk   (clock_entrada),
    .rst_n (botao),
    .d     (liga),
    .q     (liga_s)
  );

  sincronizador u_sinc_obst (
    .clk   (clock_entrada),
    .rst_n (botao),
    .d     (obstaculo),
    .q     (obst_s)
  );

  // Remembers the previous synchronized step level for rise detection
  always_ff @(posedge clock_entrada or negedge botao) begin
    if (!botao) begin
      passo_ant_r <= 1'b0;
    end else begin
      passo_ant_r <= passo_s;
    end
  end

  assign tick_s = passo_s & ~passo_ant_r;

  // Motor pattern {esq, dir}; each motor is {frente, re}, never both
  function automatic logic [3:0] motores(input estado_t s);
    logic [3:0] m;
    case (s)
      PARADO:   m = 4'b00_00;
      FRENTE:   m = 4'b10_10;
      RE:       m = 4'b01_01;
      GIRA_ESQ: m = 4'b01_10;
      GIRA_DIR: m = 4'b10_01;
      default:  m = 4'b00_00;
    endcase
    return m;
  endfunction

  // Next-state, step counter, side flag and obstacle counter
  always_comb begin
    estado_nxt_s   = estado_r;
    cont_nxt_s     = cont_r;
    lado_nxt_s     = lado_r;
    obst_cnt_nxt_s = obst_cnt_r;
    if (!liga_s) begin
      estado_nxt_s = PARADO;
      cont_nxt_s   = 4'd0;
      lado_nxt_s   = 1'b0;
    end else begin
      case (estado_r)
        PARADO: begin
          estado_nxt_s = FRENTE;
          cont_nxt_s   = 4'd0;
        end
        FRENTE: begin
          if (obst_s) begin
            estado_nxt_s = RE;
            cont_nxt_s   = 4'd0;
            if (obst_cnt_r != 4'd15) begin
              obst_cnt_nxt_s = obst_cnt_r + 4'd1;
            end else begin
              obst_cnt_nxt_s = obst_cnt_r;
            end
          end else if (tick_s) begin
            if (cont_r == LIM_FRENTE) begin
              estado_nxt_s = lado_r ? GIRA_DIR : GIRA_ESQ;
              cont_nxt_s   = 4'd0;
            end else begin
              cont_nxt_s = cont_r + 4'd1;
            end
          end else begin
            cont_nxt_s = cont_r;
          end
        end
        GIRA_ESQ, GIRA_DIR: begin
          if (tick_s) begin
            if (cont_r == LIM_GIRO) begin
              estado_nxt_s = FRENTE;
              cont_nxt_s   = 4'd0;
              lado_nxt_s   = ~lado_r;
            end else begin
              cont_nxt_s = cont_r + 4'd1;
            end
          end else begin
            cont_nxt_s = cont_r;
          end
        end
        RE: begin
          if (tick_s) begin
            if (cont_r == LIM_RE) begin
              estado_nxt_s = lado_r ? GIRA_DIR : GIRA_ESQ;
              cont_nxt_s   = 4'd0;
            end else begin
              cont_nxt_s = cont_r + 4'd1;
            end
          end else begin
            cont_nxt_s = cont_r;
          end
        end
        default: begin
          estado_nxt_s = PARADO;
          cont_nxt_s   = 4'd0;
          lado_nxt_s   = 1'b0;
        end
      endcase
    end
  end

  assign motores_nxt_s = motores(estado_nxt_s);

  // Controller state and registered outputs, all updated on the same edge
  always_ff @(posedge clock_entrada or negedge botao) begin
    if (!botao) begin
      estado_r    <= PARADO;
      cont_r      <= 4'd0;
      lado_r      <= 1'b0;
      obst_cnt_r  <= 4'd0;
      motor_esq_r <= 2'b00;
      motor_dir_r <= 2'b00;
    end else begin
      estado_r    <= estado_nxt_s;
      cont_r      <= cont_nxt_s;
      lado_r      <= lado_nxt_s;
      obst_cnt_r  <= obst_cnt_nxt_s;
      motor_esq_r <= motores_nxt_s[3:2];
      motor_dir_r <= motores_nxt_s[1:0];
    end
  end

  assign estado              = estado_r;
  assign motor_esq           = motor_esq_r;
  assign motor_dir           = motor_dir_r;
  assign contador_obstaculos = obst_cnt_r;

endmodule

// File: tb/tb_controlador_brinquedo.sv
// Directed bench for controlador_brinquedo with a cycle-level reference model.
module tb_controlador_brinquedo;

  localparam int PF = 4;
  localparam int PG = 2;
  localparam int PR = 2;

  logic       clock_entrada = 1'b0;
  logic       botao;
  logic       passo;
  logic       liga;
  logic       obstaculo;
  logic [1:0] motor_esq;
  logic [1:0] motor_dir;
  logic [2:0] estado;
  logic [3:0] contador_obstaculos;

  int checks   = 0;
  int failures = 0;

  controlador_brinquedo #(
    .PASSOS_FRENTE (PF),
    .PASSOS_GIRO   (PG),
    .PASSOS_RE     (PR)
  ) dut (
    .clock_entrada       (clock_entrada),
    .botao               (botao),
    .passo               (passo),
    .liga                (liga),
    .obstaculo           (obstaculo),
    .motor_esq           (motor_esq),
    .motor_dir           (motor_dir),
    .estado              (estado),
    .contador_obstaculos (contador_obstaculos)
  );

  always #5 clock_entrada = ~clock_entrada;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: inputs seen by the controller are the values present two edges
  // earlier; a tick is a 0->1 between the values three and two edges earlier.
  logic [2:0] m_state, n_state;
  logic [3:0] m_cnt, n_cnt;
  logic       m_lado, n_lado;
  logic [3:0] m_obs, n_obs;
  logic p1, p2, p3, l1, l2, o1, o2;
  logic tk;
  logic [1:0] tab_esq [0:4];
  logic [1:0] tab_dir [0:4];

  initial begin
    tab_esq = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    tab_dir = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b01};
  end

  function automatic int limite(input logic [2:0] s);
    if (s == 3'd1) return PF;
    else if (s == 3'd4) return PR;
    else return PG;
  endfunction

  always_comb begin
    n_state = m_state;
    n_cnt   = m_cnt;
    n_lado  = m_lado;
    n_obs   = m_obs;
    tk      = p2 && !p3;
    if (!l2) begin
      n_state = 3'd0;
      n_cnt   = 4'd0;
      n_lado  = 1'b0;
    end else if (m_state == 3'd0) begin
      n_state = 3'd1;
      n_cnt   = 4'd0;
    end else if (m_state == 3'd1 && o2) begin
      n_state = 3'd4;
      n_cnt   = 4'd0;
      n_obs   = (m_obs == 4'd15) ? 4'd15 : m_obs + 4'd1;
    end else if (tk) begin
      if (int'(m_cnt) + 1 >= limite(m_state)) begin
        n_cnt = 4'd0;
        if (m_state == 3'd1 || m_state == 3'd4) begin
          n_state = m_lado ? 3'd3 : 3'd2;
        end else begin
          n_state = 3'd1;
          n_lado  = ~m_lado;
        end
      end else begin
        n_cnt = m_cnt + 4'd1;
      end
    end else begin
      n_cnt = m_cnt;
    end
  end

  always @(posedge clock_entrada or negedge botao) begin
    if (!botao) begin
      m_state <= 3'd0; m_cnt <= 4'd0; m_lado <= 1'b0; m_obs <= 4'd0;
      p1 <= 1'b0; p2 <= 1'b0; p3 <= 1'b0;
      l1 <= 1'b0; l2 <= 1'b0; o1 <= 1'b0; o2 <= 1'b0;
    end else begin
      m_state <= n_state; m_cnt <= n_cnt; m_lado <= n_lado; m_obs <= n_obs;
      p3 <= p2; p2 <= p1; p1 <= passo;
      l2 <= l1; l1 <= liga;
      o2 <= o1; o1 <= obstaculo;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clock_entrada) begin
    check("m_estado", {5'd0, estado}, {5'd0, m_state});
    check("m_motor_esq", {6'd0, motor_esq}, {6'd0, tab_esq[m_state]});
    check("m_motor_dir", {6'd0, motor_dir}, {6'd0, tab_dir[m_state]});
    check("m_contador", {4'd0, contador_obstaculos}, {4'd0, m_obs});
    check("motor_11", {7'd0, (motor_esq == 2'b11) || (motor_dir == 2'b11)}, 8'd0);
  end

  task automatic pulso(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_entrada); passo = 1'b1;
      repeat (4) @(negedge clock_entrada);
      passo = 1'b0;
      repeat (3) @(negedge clock_entrada);
    end
  endtask

  task automatic obst_evento();
    @(negedge clock_entrada); obstaculo = 1'b1;
    repeat (2) @(negedge clock_entrada);
    obstaculo = 1'b0;
    repeat (2) @(negedge clock_entrada);
  endtask

  task automatic zeros(input string tag);
    check({tag, "_estado"}, {5'd0, estado}, 8'd0);
    check({tag, "_motores"}, {4'd0, motor_esq, motor_dir}, 8'd0);
    check({tag, "_contador"}, {4'd0, contador_obstaculos}, 8'd0);
  endtask

  initial begin
    botao = 1'b0; passo = 1'b1; liga = 1'b1; obstaculo = 1'b0;
    repeat (3) @(negedge clock_entrada);
    zeros("reset");
    botao = 1'b1;
    @(posedge clock_entrada); #1 check("rel_edge1", {5'd0, estado}, 8'd0);
    @(posedge clock_entrada); #1 check("rel_edge2", {5'd0, estado}, 8'd0);
    @(posedge clock_entrada); #1 check("rel_edge3", {5'd0, estado}, 8'd1);
    check("rel_motores", {4'd0, motor_esq, motor_dir}, 8'b1010);

    @(negedge clock_entrada); passo = 1'b0;
    repeat (4) @(negedge clock_entrada);
    pulso(4);
    check("frente_gira_esq", {5'd0, estado}, 8'd2);
    check("gira_esq_motores", {4'd0, motor_esq, motor_dir}, 8'b0110);
    pulso(2);
    check("gira_frente", {5'd0, estado}, 8'd1);
    pulso(4);
    check("frente_gira_dir", {5'd0, estado}, 8'd3);
    check("gira_dir_motores", {4'd0, motor_esq, motor_dir}, 8'b1001);
    pulso(2);
    check("volta_frente", {5'd0, estado}, 8'd1);

    pulso(2);
    @(negedge clock_entrada); obstaculo = 1'b1;
    @(posedge clock_entrada); @(posedge clock_entrada);
    #1 check("obst_edge2", {5'd0, estado}, 8'd1);
    @(posedge clock_entrada);
    #1 check("obst_edge3", {5'd0, estado}, 8'd4);
    check("obst_contador", {4'd0, contador_obstaculos}, 8'd1);
    check("re_motores", {4'd0, motor_esq, motor_dir}, 8'b0101);
    @(negedge clock_entrada); obstaculo = 1'b0;
    pulso(2);
    check("re_gira_esq", {5'd0, estado}, 8'd2);
    obst_evento();
    check("obst_ignorado", {4'd0, contador_obstaculos}, 8'd1);
    pulso(2);
    check("frente_lado1", {5'd0, estado}, 8'd1);

    for (int k = 0; k < 16; k++) begin
      obst_evento();
      pulso(4);
    end
    check("contador_sat", {4'd0, contador_obstaculos}, 8'd15);
    check("sat_frente", {5'd0, estado}, 8'd1);

    obst_evento();
    check("re_antes_liga", {5'd0, estado}, 8'd4);
    pulso(1);
    @(negedge clock_entrada); passo = 1'b1; liga = 1'b0;
    repeat (3) @(posedge clock_entrada);
    #1 check("liga0_estado", {5'd0, estado}, 8'd0);
    check("liga0_motores", {4'd0, motor_esq, motor_dir}, 8'd0);
    @(negedge clock_entrada); passo = 1'b0;
    repeat (3) @(negedge clock_entrada);
    liga = 1'b1;
    repeat (4) @(negedge clock_entrada);
    check("religa_frente", {5'd0, estado}, 8'd1);
    pulso(4);
    check("religa_lado0", {5'd0, estado}, 8'd2);

    pulso(2);
    pulso(4);
    check("pre_reset_gira_dir", {5'd0, estado}, 8'd3);
    @(negedge clock_entrada); passo = 1'b1;
    #2 botao = 1'b0; liga = 1'b0;
    #1 zeros("pulso_reset");
    repeat (3) @(negedge clock_entrada);
    zeros("pulso_reset_hold");
    botao = 1'b1;
    repeat (4) @(negedge clock_entrada);
    passo = 1'b0;
    repeat (3) @(negedge clock_entrada);
    pulso(2);
    check("pos_reset_parado", {5'd0, estado}, 8'd0);
    liga = 1'b1;
    repeat (4) @(negedge clock_entrada);
    check("pos_reset_frente", {5'd0, estado}, 8'd1);
    pulso(4);
    check("pos_reset_gira_esq", {5'd0, estado}, 8'd2);
    check("pos_reset_contador", {4'd0, contador_obstaculos}, 8'd0);

    @(negedge clock_entrada);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
